xbus_dram: RTL and testbench
============================

// Module: xbus_dram
// PURPOSE
//  Xbus slave bridging 22-bit word-addressed Xbus cycles to the SDRAM controller port.
//  Decodes the DRAM window (octal 0..16777777), forwards one read or write per request and returns an ack.
//  Sits under the bus interface; either the CPU or the disk DMA master drives it (muxed upstream).
// PARAMETERS
//  ADDR_W     22            Xbus/SDRAM word-address width
//  DATA_W     32            data width
//  DRAM_LIMIT 22'o17000000  first address outside the DRAM window (exclusive)
//  WDOG_MAX   63            watchdog cycles before forced ack (only with XBUS_DRAM_WDOG_EN)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       synchronous, active-high reset
//  addr           in   22      Xbus word address
//  datain         in   32      write data from bus master
//  dataout        out  32      read data to bus master
//  req            in   1       bus request, level, held until ack seen
//  write          in   1       1=write, 0=read; valid while req
//  ack            out  1       cycle complete
//  decode         out  1       addr inside DRAM window (combinational)
//  sdram_addr     out  22      SDRAM word address
//  sdram_data_in  in   32      SDRAM read data, valid with sdram_ready
//  sdram_data_out out  32      SDRAM write data
//  sdram_req      out  1       SDRAM access request, level
//  sdram_ready    in   1       read data valid (1-cycle pulse)
//  sdram_write    out  1       SDRAM write enable, qualifies sdram_req
//  sdram_done     in   1       write completed (1-cycle pulse)
// BEHAVIOUR
//  - decode = (addr < DRAM_LIMIT); purely combinational, independent of req.
//  - FSM states IDLE, ACCESS, ACK. Reset: state=IDLE; ack, sdram_req, sdram_write=0; dataout, sdram_addr, sdram_data_out=0.
//  - IDLE: on req & decode, latch addr->sdram_addr, datain->sdram_data_out, write->sdram_write; go ACCESS.
//    req & ~decode: ignored, stay IDLE, no ack.
//  - ACCESS: sdram_req=1. Read: on sdram_ready, latch sdram_data_in->dataout, go ACK.
//    Write: on sdram_done go ACK. Pulse from the wrong class (ready on write, done on read) ignored.
//  - ACK: ack=1 (registered), sdram_req=0; dataout already valid in first ACK cycle.
//    Stay while req=1; on req=0 return IDLE next cycle (ack falls then).
//  - Latency: ack rises 1 cycle after the ready/done pulse; minimum req-to-ack = 3 cycles.
//  - Back-to-back: new request accepted only from IDLE, i.e. req must drop for >=1 cycle between cycles.
//  - req dropped during ACCESS (master abort): finish the SDRAM access, enter ACK, then IDLE next cycle.
//  - Addr/data/write changes after acceptance ignored (latched copies used).
//  - Reset mid-access: immediate IDLE, sdram_req deasserted same edge; pending ready/done discarded.
//  - dataout holds last read value until next read completes.
// CONFIGURATION
//  - XBUS_DRAM_WDOG_EN defined: counter runs in ACCESS; at WDOG_MAX cycles without ready/done,
//    drop sdram_req, set dataout=32'h0 (reads), enter ACK. Counter cleared on leaving ACCESS.
//  - Undefined: ACCESS waits indefinitely; no counter logic synthesised.
// STRUCTURE
//  - Shared package xbus_pkg: ADDR_W/DATA_W, DRAM_LIMIT and other Xbus window base constants,
//    xbus_dram state enum.
//  - Single flat module; watchdog is inline logic, no sub-module.
// TESTING
//  - Read 22'o00001234, SDRAM returns 32'hDEADBEEF with ready 4 cycles later -> sdram_req=1 with addr 1234,
//    sdram_write=0, ack 1 cycle after ready, dataout=DEADBEEF, IDLE cycle after req drops.
//  - Write 22'o16777777 data 32'h12345678 -> sdram_write=1, data_out=12345678; ack 1 cycle after done.
//  - req at addr 22'o17000000 -> decode=0, sdram_req never asserted, ack stays 0 for 100 cycles.
//  - Reset asserted in ACCESS -> next edge sdram_req=0, ack=0, state IDLE; later ready pulse ignored.
//  - req dropped in ACCESS, then done arrives -> single ack cycle, then IDLE; next req serviced normally.
//  - WDOG_EN built, SDRAM silent -> ack at cycle WDOG_MAX+2, dataout=0; without macro no ack.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared Xbus definitions: bus widths, address-window bases and the DRAM bridge state encoding.
package xbus_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    // Word-address window bases; DRAM occupies everything below the I/O region.
    localparam logic [ADDR_W-1:0] XBUS_DRAM_BASE = 22'o00000000;
    localparam logic [ADDR_W-1:0] DRAM_LIMIT     = 22'o17000000;
    localparam logic [ADDR_W-1:0] XBUS_IO_BASE   = 22'o17000000;
    localparam logic [ADDR_W-1:0] XBUS_DISK_BASE = 22'o17377770;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } xbus_dram_state_t;

endpackage

// File: rtl/xbus_dram.sv
// Xbus slave that forwards one decoded DRAM-window read or write to the SDRAM controller and acks it.
// Optional watchdog forcing an ack on a silent SDRAM is enabled with `define XBUS_DRAM_WDOG_EN.
module xbus_dram
    import xbus_pkg::*;
#(
    parameter int                    P_ADDR_W     = ADDR_W,
    parameter int                    P_DATA_W     = DATA_W,
    parameter logic [P_ADDR_W-1:0]   P_DRAM_LIMIT = P_ADDR_W'(DRAM_LIMIT)
`ifdef XBUS_DRAM_WDOG_EN
    ,
    parameter int                    WDOG_MAX     = 63
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [P_ADDR_W-1:0] addr,
    input  logic [P_DATA_W-1:0] datain,
    output logic [P_DATA_W-1:0] dataout,
    input  logic                req,
    input  logic                write,
    output logic                ack,
    output logic                decode,
    output logic [P_ADDR_W-1:0] sdram_addr,
    input  logic [P_DATA_W-1:0] sdram_data_in,
    output logic [P_DATA_W-1:0] sdram_data_out,
    output logic                sdram_req,
    input  logic                sdram_ready,
    output logic                sdram_write,
    input  logic                sdram_done
);

    xbus_dram_state_t      r_state;
    xbus_dram_state_t      w_next_state;
    logic [P_ADDR_W-1:0]   r_sdram_addr;
    logic [P_DATA_W-1:0]   r_sdram_data_out;
    logic [P_DATA_W-1:0]   r_dataout;
    logic                  r_sdram_write;
    logic                  w_accept;
    logic                  w_rsp;
    logic                  w_wdog_fire;

    assign decode   = (addr < P_DRAM_LIMIT);
    assign w_accept = (r_state == ST_IDLE) && req && decode;
    // Only the completion pulse matching the latched direction counts.
    assign w_rsp    = r_sdram_write ? sdram_done : sdram_ready;

`ifdef XBUS_DRAM_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_MAX + 1);
    logic [WDOG_W-1:0] r_wdog;

    always_ff @(posedge clk) begin
        if (reset)
            r_wdog <= '0;
        else if (r_state == ST_ACCESS && w_next_state == ST_ACCESS)
            r_wdog <= r_wdog + WDOG_W'(1);
        else
            r_wdog <= '0;
    end

    assign w_wdog_fire = (r_state == ST_ACCESS) && !w_rsp && (r_wdog == WDOG_W'(WDOG_MAX - 1));
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_rsp || w_wdog_fire) w_next_state = ST_ACK;
            ST_ACK:    if (!req) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdram_addr     <= '0;
            r_sdram_data_out <= '0;
            r_sdram_write    <= 1'b0;
            r_dataout        <= '0;
        end else begin
            if (w_accept) begin
                r_sdram_addr     <= addr;
                r_sdram_data_out <= datain;
                r_sdram_write    <= write;
            end
            if (r_state == ST_ACCESS && !r_sdram_write) begin
                if (sdram_ready)
                    r_dataout <= sdram_data_in;
                else if (w_wdog_fire)
                    r_dataout <= '0;
            end
        end
    end

    // Both strobes decode directly from the state flop, so they are glitch-free registered levels.
    assign ack            = (r_state == ST_ACK);
    assign sdram_req      = (r_state == ST_ACCESS);
    assign sdram_addr     = r_sdram_addr;
    assign sdram_data_out = r_sdram_data_out;
    assign sdram_write    = r_sdram_write;
    assign dataout        = r_dataout;

endmodule

// File: tb/tb_xbus_dram.sv
// Directed bench for xbus_dram: read/write, window boundary, reset mid-access, master abort, watchdog.
// Read data expectations are queued when a read is issued and popped when its ack is seen.
module tb_xbus_dram;
    import xbus_pkg::*;

    localparam int TB_WDOG_MAX = 63;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              req;
    logic              write;
    logic              ack;
    logic              decode;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_data_in;
    logic [DATA_W-1:0] sdram_data_out;
    logic              sdram_req;
    logic              sdram_ready;
    logic              sdram_write;
    logic              sdram_done;

    int n_pass  = 0;
    int n_total = 0;
    logic [DATA_W-1:0] exp_q[$];

    xbus_dram dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .datain         (datain),
        .dataout        (dataout),
        .req            (req),
        .write          (write),
        .ack            (ack),
        .decode         (decode),
        .sdram_addr     (sdram_addr),
        .sdram_data_in  (sdram_data_in),
        .sdram_data_out (sdram_data_out),
        .sdram_req      (sdram_req),
        .sdram_ready    (sdram_ready),
        .sdram_write    (sdram_write),
        .sdram_done     (sdram_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_ack(input int max_cycles, output int cycles);
        cycles = 0;
        while (ack !== 1'b1 && cycles < max_cycles) begin
            step();
            cycles++;
        end
        check("ack_within_budget", {31'd0, ack}, 32'd1);
    endtask

    task automatic check_read_data(input string tag);
        logic [DATA_W-1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, dataout, exp);
        end
    endtask

    initial begin : stim
        int cyc;
        int bad;

        reset = 1'b1; addr = '0; datain = '0; req = 1'b0; write = 1'b0;
        sdram_data_in = '0; sdram_ready = 1'b0; sdram_done = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_ack",       {31'd0, ack},         32'd0);
        check("rst_sdram_req", {31'd0, sdram_req},   32'd0);
        check("rst_sdram_wr",  {31'd0, sdram_write}, 32'd0);
        check("rst_dataout",   dataout,              32'd0);
        check("rst_sdram_addr", {10'd0, sdram_addr}, 32'd0);
        check("rst_sdram_dout", sdram_data_out,      32'd0);

        // Read with a 4-cycle SDRAM latency; address changes after acceptance must be ignored.
        addr = 22'o00001234; write = 1'b0; req = 1'b1;
        #1 check("rd_decode", {31'd0, decode}, 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        step();
        check("rd_sdram_req",  {31'd0, sdram_req},   32'd1);
        check("rd_sdram_addr", {10'd0, sdram_addr},  32'o1234);
        check("rd_sdram_wr",   {31'd0, sdram_write}, 32'd0);
        addr = 22'o00007777; write = 1'b1;
        step(); step(); step();
        check("rd_no_early_ack", {31'd0, ack}, 32'd0);
        check("rd_addr_held",    {10'd0, sdram_addr}, 32'o1234);
        sdram_ready = 1'b1; sdram_data_in = 32'hDEADBEEF;
        step();
        sdram_ready = 1'b0; sdram_data_in = 32'h0;
        check("rd_ack_after_ready", {31'd0, ack}, 32'd1);
        check("rd_req_dropped",     {31'd0, sdram_req}, 32'd0);
        check_read_data("rd_dataout");
        step();
        check("rd_ack_held", {31'd0, ack}, 32'd1);
        req = 1'b0;
        step();
        check("rd_ack_fall", {31'd0, ack}, 32'd0);
        step();

        // Write at the last DRAM word; a stray ready pulse must not complete it.
        addr = 22'o16777777; datain = 32'h12345678; write = 1'b1; req = 1'b1;
        #1 check("wr_decode_top", {31'd0, decode}, 32'd1);
        step();
        datain = 32'hFFFFFFFF;
        check("wr_sdram_wr",   {31'd0, sdram_write}, 32'd1);
        check("wr_sdram_dout", sdram_data_out,       32'h12345678);
        check("wr_sdram_addr", {10'd0, sdram_addr},  32'o16777777);
        sdram_ready = 1'b1; sdram_data_in = 32'h55555555;
        step();
        sdram_ready = 1'b0;
        check("wr_ready_ignored", {31'd0, ack}, 32'd0);
        check("wr_still_req",     {31'd0, sdram_req}, 32'd1);
        sdram_done = 1'b1;
        step();
        sdram_done = 1'b0;
        check("wr_ack_after_done", {31'd0, ack}, 32'd1);
        check("wr_dataout_held",   dataout, 32'hDEADBEEF);
        req = 1'b0;
        step();
        check("wr_ack_fall", {31'd0, ack}, 32'd0);

        // First address outside the window: never forwarded, never acked.
        addr = 22'o17000000; write = 1'b0; req = 1'b1;
        #1 check("oow_decode", {31'd0, decode}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ack !== 1'b0 || sdram_req !== 1'b0) bad++;
        end
        check("oow_silent_100", bad, 32'd0);
        req = 1'b0;
        step();

        // Reset during ACCESS; the late ready pulse must be discarded.
        addr = 22'o40; req = 1'b1; write = 1'b0;
        step();
        check("rst_mid_req_on", {31'd0, sdram_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; req = 1'b0;
        check("rst_mid_req_off", {31'd0, sdram_req}, 32'd0);
        check("rst_mid_ack",     {31'd0, ack},       32'd0);
        sdram_ready = 1'b1; sdram_data_in = 32'hCAFEF00D;
        step();
        sdram_ready = 1'b0;
        check("rst_late_ready_ack", {31'd0, ack}, 32'd0);
        check("rst_late_ready_dout", dataout, 32'h0);

        // Master abort: req drops in ACCESS, done still produces exactly one ack cycle.
        addr = 22'o5; datain = 32'hAAAA5555; write = 1'b1; req = 1'b1;
        step();
        req = 1'b0;
        step(); step();
        check("abort_still_access", {31'd0, sdram_req}, 32'd1);
        sdram_done = 1'b1;
        step();
        sdram_done = 1'b0;
        check("abort_ack_once", {31'd0, ack}, 32'd1);
        step();
        check("abort_ack_gone", {31'd0, ack}, 32'd0);
        step();

        // Normal read right after the abort.
        addr = 22'o7; write = 1'b0; req = 1'b1;
        exp_q.push_back(32'h01020304);
        step();
        check("post_abort_addr", {10'd0, sdram_addr}, 32'o7);
        sdram_ready = 1'b1; sdram_data_in = 32'h01020304;
        step();
        sdram_ready = 1'b0;
        wait_ack(4, cyc);
        check_read_data("post_abort_dataout");
        req = 1'b0;
        step();

        // Silent SDRAM: watchdog forces a zero-data ack, otherwise the bridge waits.
        addr = 22'o11; write = 1'b0; req = 1'b1;
`ifdef XBUS_DRAM_WDOG_EN
        exp_q.push_back(32'h0);
        wait_ack(TB_WDOG_MAX + 10, cyc);
        check("wdog_ack_cycle", cyc, TB_WDOG_MAX + 1);
        check_read_data("wdog_dataout");
        req = 1'b0;
        step();
`else
        bad = 0;
        for (int i = 0; i < TB_WDOG_MAX + 40; i++) begin
            step();
            if (ack !== 1'b0 || sdram_req !== 1'b1) bad++;
        end
        check("nowdog_waits", bad, 32'd0);
        reset = 1'b1; req = 1'b0;
        step();
        reset = 1'b0;
`endif
        step();
        check("final_idle_ack", {31'd0, ack}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
